// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit bus master: access sizes, FSM states
// and bus constants, plus small helpers used by the master and its bench.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic       BUS_RD       = 1'b0;
  localparam logic       BUS_WR       = 1'b1;
  localparam logic [1:0] BUS_LEN_BYTE = 2'b00;

  // Index of the final byte beat for a legal size (N-1).
  function automatic logic [1:0] last_beat(input size_e sz);
    case (sz)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// CPU request/response and byte-bus signals of the load/store unit.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// initiator holds valid and its payload stable until then. rsp_valid has no ready.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_rw;
  logic [1:0]        bus_len;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_write;
  logic [7:0]        bus_read;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_rw, bus_len, bus_addr, bus_write,
    input  bus_ready, bus_read
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_rw, bus_len, bus_addr, bus_write,
    output bus_ready, bus_read
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes to 32 bits.
// Also used by the CPU writeback path, so it stays purely combinational.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = '0;
    case (size)
      SZ_BYTE: data_out = is_unsigned ? {24'h0, data_in[7:0]}
                                      : {{24{data_in[7]}}, data_in[7:0]};
      SZ_HALF: data_out = is_unsigned ? {16'h0, data_in[15:0]}
                                      : {{16{data_in[15]}}, data_in[15:0]};
      SZ_WORD: data_out = data_in;
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: splits one CPU access into byte beats and returns a
// one-cycle response. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_bus_master_if.master    io,
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic                we_q, we_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                bad_req;
  logic [31:0]         ext_data;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    bad_req = (size_e'(io.req_size) == SZ_ILL) ||
              is_misaligned(size_e'(io.req_size), io.req_addr[1:0]);
`else
    bad_req = (size_e'(io.req_size) == SZ_ILL);
`endif
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    case (state_q)
      ST_IDLE: begin
        if (io.req_valid) begin
          we_d    = io.req_we;
          size_d  = size_e'(io.req_size);
          uns_d   = io.req_unsigned;
          addr_d  = io.req_addr;
          wdata_d = io.req_wdata;
          asm_d   = '0;
          beat_d  = 2'd0;
          err_d   = bad_req;
          state_d = bad_req ? ST_RESP : ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (io.bus_ready) begin
          if (!we_q) asm_d[{beat_q, 3'b000} +: 8] = io.bus_read;
          if (beat_q == last_beat(size_q)) state_d = ST_RESP;
          else                             beat_d  = beat_q + 2'd1;
        end
      end
      ST_RESP: begin
        beat_d  = 2'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
    end
  end

  lsu_load_extend u_ext (
    .size        (size_q),
    .is_unsigned (uns_q),
    .data_in     (asm_q),
    .data_out    (ext_data)
  );

  // Outputs decode straight from state so an async reset silences the bus at once.
  always_comb begin
    io.req_ready = (state_q == ST_IDLE);
    io.bus_valid = (state_q == ST_BEAT);
    io.bus_len   = BUS_LEN_BYTE;
    io.bus_rw    = io.bus_valid ? we_q : BUS_RD;
    io.bus_addr  = io.bus_valid ? (addr_q + {{(ADDR_W-2){1'b0}}, beat_q}) : '0;
    io.bus_write = io.bus_valid ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
    io.rsp_valid = (state_q == ST_RESP);
    io.rsp_err   = io.rsp_valid && err_q;
    io.rsp_rdata = (io.rsp_valid && !err_q && !we_q) ? ext_data : 32'h0;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized bench for lsu_bus_master against a byte-memory reference model.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  lsu_bus_master_if #(.ADDR_W(32)) bif ();

  lsu_bus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bif.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [31:0] exp_q[$];      // expected beat addresses
  logic [7:0]  exp_wd_q[$];   // expected store bytes
  logic [7:0]  mem [256];
  logic [31:0] last_rdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall_mode);
    int          n;
    int          stalls[4];
    int          stall_left;
    int          beat_idx;
    int          exp_lat;
    longint      v;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        done;

    exp_err = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) exp_err = 1'b1;
`endif
    n = exp_err ? 0 : (1 << size);
    exp_q.delete();
    exp_wd_q.delete();
    v = 0;
    exp_lat = 1 + n;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = addr + 32'(i);
      exp_q.push_back(a);
      exp_wd_q.push_back(8'((wdata >> (8 * i)) & 32'hFF));
      v = v + (longint'(mem[a[7:0]]) << (8 * i));
      stalls[i] = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
      exp_lat += stalls[i];
    end
    if (!we && n > 0 && n < 4 && !uns && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    exp_rdata = (we || exp_err) ? 32'h0 : v[31:0];

    bif.req_valid    = 1'b1;
    bif.req_we       = we;
    bif.req_size     = size;
    bif.req_unsigned = uns;
    bif.req_addr     = addr;
    bif.req_wdata    = wdata;
    check_val("req_ready_idle", {31'b0, bif.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bif.req_valid    = 1'b0;
    bif.req_we       = 1'($urandom);
    bif.req_size     = 2'($urandom);
    bif.req_unsigned = 1'($urandom);
    bif.req_addr     = $urandom;
    bif.req_wdata    = $urandom;

    done       = 1'b0;
    beat_idx   = 0;
    stall_left = (n > 0) ? stalls[0] : 0;
    for (int c = 1; c <= 64 && !done; c++) begin
      @(negedge clk);
      bif.bus_ready = 1'b0;
      bif.bus_read  = 8'($urandom);
      if (bif.bus_valid) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", {31'b0, bif.bus_valid}, 32'd0);
        end else begin
          check_val("bus_addr", bif.bus_addr, exp_q[0]);
          check_val("bus_rw", {31'b0, bif.bus_rw}, {31'b0, we});
          check_val("bus_len", {30'b0, bif.bus_len}, 32'd0);
          if (we) check_val("bus_write", {24'b0, bif.bus_write}, {24'b0, exp_wd_q[0]});
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            bif.bus_ready = 1'b1;
            bif.bus_read  = mem[exp_q[0][7:0]];
            if (we) mem[exp_q[0][7:0]] = exp_wd_q[0];
            void'(exp_q.pop_front());
            void'(exp_wd_q.pop_front());
            beat_idx++;
            if (beat_idx < n) stall_left = stalls[beat_idx];
          end
        end
      end
      if (bif.rsp_valid) begin
        check_val("rsp_latency", 32'(c), 32'(exp_lat));
        check_val("rsp_err", {31'b0, bif.rsp_err}, {31'b0, exp_err});
        check_val("rsp_rdata", bif.rsp_rdata, exp_rdata);
        check_val("beats_left", 32'(exp_q.size()), 32'd0);
        last_rdata = bif.rsp_rdata;
        done = 1'b1;
      end
    end
    check_val("rsp_timeout", {31'b0, done}, 32'd1);
    bif.bus_ready = 1'b0;
    @(negedge clk);
    check_val("rsp_one_cycle", {31'b0, bif.rsp_valid}, 32'd0);
    check_val("bus_idle_after", {31'b0, bif.bus_valid}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    last_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst_n            = 1'b0;
    bif.req_valid    = 1'b0;
    bif.req_we       = 1'b0;
    bif.req_size     = 2'b00;
    bif.req_unsigned = 1'b0;
    bif.req_addr     = '0;
    bif.req_wdata    = '0;
    bif.bus_ready    = 1'b0;
    bif.bus_read     = 8'h00;

    #3;
    check_val("rst_req_ready", {31'b0, bif.req_ready}, 32'd1);
    check_val("rst_bus_valid", {31'b0, bif.bus_valid}, 32'd0);
    check_val("rst_bus_rw", {31'b0, bif.bus_rw}, 32'd0);
    check_val("rst_bus_addr", bif.bus_addr, 32'd0);
    check_val("rst_bus_write", {24'b0, bif.bus_write}, 32'd0);
    check_val("rst_rsp_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check_val("rst_rsp_err", {31'b0, bif.rsp_err}, 32'd0);
    check_val("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word load, ready high
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    check_val("lw_40_value", last_rdata, 32'h44332211);

    // Byte load, signed then unsigned
    mem[8'h40] = 8'h80;
    run_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 0);
    check_val("lb_signed", last_rdata, 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 0);
    check_val("lbu_unsigned", last_rdata, 32'h00000080);

    // Half store with two stall cycles per beat
    run_req(1'b1, 2'b01, 1'b0, 32'h40, 32'h1234BEEF, 2);

    // Misaligned word load
    mem[8'h44] = 8'h55; mem[8'h45] = 8'h66;
    run_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 0);

    // Half load wrapping the address space, and the illegal size
    run_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1);
    run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0);
    check_val("ill_rdata_zero", last_rdata, 32'h0);

    // Reset during beat 2 of a word load
    bif.req_valid = 1'b1;
    bif.req_we    = 1'b0;
    bif.req_size  = 2'b10;
    bif.req_addr  = 32'h80;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_read  = mem[8'h80];
    @(negedge clk);
    check_val("abort_beat2_valid", {31'b0, bif.bus_valid}, 32'd1);
    check_val("abort_beat2_addr", bif.bus_addr, 32'h81);
    rst_n = 1'b0;
    #1;
    check_val("abort_bus_valid", {31'b0, bif.bus_valid}, 32'd0);
    check_val("abort_rsp_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check_val("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    bif.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_no_rsp", {31'b0, bif.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_no_rsp_post", {31'b0, bif.rsp_valid}, 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 32'h91, 32'h0, 0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
